bus_fill_arbiter: RTL and testbench



---
 rtl/bus_fill_arbiter_pkg.sv | 39 +++
 rtl/bus_fill_arbiter_vec_extend.sv | 19 +
 rtl/bus_fill_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_bus_fill_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_fill_arbiter_pkg.sv
// Shared definitions for bus_fill_arbiter: fill modes, FSM states, idle bus value.
// Optional feature macro: ARB_TRISTATE_EN (tri-state idle value and z fill for mode 11).
package bus_fill_arbiter_pkg;

    localparam logic [1:0] FILL_ZERO = 2'b00;
    localparam logic [1:0] FILL_SIGN = 2'b01;
    localparam logic [1:0] FILL_ONES = 2'b10;
    localparam logic [1:0] FILL_Z    = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DRIVE = 2'b01,
        ST_TURN  = 2'b10
    } state_t;

`ifdef ARB_TRISTATE_EN
    localparam logic [31:0] IDLE_VALUE = 32'hzzzz_zzzz;
`else
    localparam logic [31:0] IDLE_VALUE = 32'h0000_0000;
`endif

    // Value of every upper bit for a given fill mode and data MSB.
    function automatic logic fill_bit(input logic [1:0] mode, input logic msb);
        logic b;
        case (mode)
            FILL_ZERO: b = 1'b0;
            FILL_SIGN: b = msb;
            FILL_ONES: b = 1'b1;
`ifdef ARB_TRISTATE_EN
            FILL_Z:    b = 1'bz;
`else
            FILL_Z:    b = 1'b0;
`endif
            default:   b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/bus_fill_arbiter_vec_extend.sv
// vec_extend_unit: widens DW-bit data to BW bits using the selected fill mode.
// Honours ARB_TRISTATE_EN through the package fill helper.
module vec_extend_unit
    import bus_fill_arbiter_pkg::*;
#(
    parameter int DW = 8,
    parameter int BW = 32
) (
    input  logic [DW-1:0] data,
    input  logic [1:0]    mode,
    output logic [BW-1:0] word
);

    // Replicate the fill bit across the upper BW-DW positions.
    always_comb begin
        word = {{(BW-DW){fill_bit(mode, data[DW-1])}}, data};
    end

endmodule

// File: rtl/bus_fill_arbiter.sv
// Round-robin arbiter sharing one registered wide bus among NREQ narrow requesters.
// Optional feature macro: ARB_TRISTATE_EN (idle bus is all z, mode 11 fills with z).
module bus_fill_arbiter
    import bus_fill_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int BW        = 32,
    parameter int MAX_BEATS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*DW-1:0] data_in,
    input  logic [NREQ*2-1:0] ext_mode,
    output logic [NREQ-1:0]   gnt,
    output logic [BW-1:0]     bus_out,
    output logic              bus_oe,
    output logic              busy
);

    localparam int OW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BCW = $clog2(MAX_BEATS + 1);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BEATS - 1);

    state_t          state_r, state_nx_s;
    logic [NREQ-1:0] gnt_r, gnt_nx_s;
    logic [OW-1:0]   owner_r, owner_nx_s;
    logic [OW-1:0]   ptr_r, ptr_nx_s;
    logic [BCW-1:0]  beat_r, beat_nx_s;
    logic [BW-1:0]   bus_out_r, bus_out_nx_s;
    logic            bus_oe_r, bus_oe_nx_s;
    logic            busy_r, busy_nx_s;

    logic [OW-1:0]   win_s;
    logic            win_vld_s;
    logic [DW-1:0]   sel_data_s;
    logic [1:0]      sel_mode_s;
    logic            sel_req_s;
    logic [BW-1:0]   ext_word_s;
    logic [OW-1:0]   ptr_after_s;

    // Round-robin search: first set request at or after the pointer, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        win_s     = '0;
        win_vld_s = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_r) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end else begin
                idx = idx;
            end
            if (!win_vld_s && req[idx]) begin
                win_vld_s = 1'b1;
                win_s     = OW'(idx);
            end else begin
                win_s     = win_s;
            end
        end
    end

    // Owner-muxed request, data and fill mode.
    always_comb begin
        sel_data_s = '0;
        sel_mode_s = FILL_ZERO;
        sel_req_s  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_r == OW'(i)) begin
                sel_data_s = data_in[i*DW +: DW];
                sel_mode_s = ext_mode[2*i +: 2];
                sel_req_s  = req[i];
            end else begin
                sel_data_s = sel_data_s;
            end
        end
    end

    vec_extend_unit #(
        .DW (DW),
        .BW (BW)
    ) u_ext (
        .data (sel_data_s),
        .mode (sel_mode_s),
        .word (ext_word_s)
    );

    // Pointer resumes just past the owner so every requester gets a turn.
    always_comb begin
        if (owner_r == OW'(NREQ - 1)) begin
            ptr_after_s = '0;
        end else begin
            ptr_after_s = owner_r + OW'(1);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nx_s   = state_r;
        gnt_nx_s     = gnt_r;
        owner_nx_s   = owner_r;
        ptr_nx_s     = ptr_r;
        beat_nx_s    = beat_r;
        bus_out_nx_s = bus_out_r;
        bus_oe_nx_s  = bus_oe_r;
        case (state_r)
            ST_IDLE: begin
                if (win_vld_s) begin
                    state_nx_s = ST_DRIVE;
                    owner_nx_s = win_s;
                    beat_nx_s  = '0;
                    for (int i = 0; i < NREQ; i++) begin
                        gnt_nx_s[i] = (win_s == OW'(i));
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (sel_req_s) begin
                    bus_out_nx_s = ext_word_s;
                    bus_oe_nx_s  = 1'b1;
                    beat_nx_s    = beat_r + BCW'(1);
                    if (beat_r == LAST_BEAT) begin
                        state_nx_s = ST_TURN;
                        gnt_nx_s   = '0;
                    end else begin
                        state_nx_s = ST_DRIVE;
                    end
                end else begin
                    state_nx_s   = ST_TURN;
                    gnt_nx_s     = '0;
                    bus_oe_nx_s  = 1'b0;
                    bus_out_nx_s = IDLE_VALUE;
                end
            end
            ST_TURN: begin
                state_nx_s   = ST_IDLE;
                bus_oe_nx_s  = 1'b0;
                bus_out_nx_s = IDLE_VALUE;
                ptr_nx_s     = ptr_after_s;
            end
            default: begin
                state_nx_s   = ST_IDLE;
                gnt_nx_s     = '0;
                bus_oe_nx_s  = 1'b0;
                bus_out_nx_s = IDLE_VALUE;
            end
        endcase
        busy_nx_s = (state_nx_s != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            gnt_r     <= '0;
            owner_r   <= '0;
            ptr_r     <= '0;
            beat_r    <= '0;
            bus_out_r <= IDLE_VALUE;
            bus_oe_r  <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            gnt_r     <= gnt_nx_s;
            owner_r   <= owner_nx_s;
            ptr_r     <= ptr_nx_s;
            beat_r    <= beat_nx_s;
            bus_out_r <= bus_out_nx_s;
            bus_oe_r  <= bus_oe_nx_s;
            busy_r    <= busy_nx_s;
        end
    end

    assign gnt     = gnt_r;
    assign bus_out = bus_out_r;
    assign bus_oe  = bus_oe_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_bus_fill_arbiter.sv
// Self-checking bench for bus_fill_arbiter: directed scenarios plus randomized
// traffic compared against a behavioural model of the arbitration rules.
module tb_bus_fill_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int MAXB = 4;

`ifdef ARB_TRISTATE_EN
    localparam logic [31:0] IDLE_W = 32'hzzzz_zzzz;
`else
    localparam logic [31:0] IDLE_W = 32'h0000_0000;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [7:0]  ext_mode;
    logic [3:0]  gnt;
    logic [31:0] bus_out;
    logic        bus_oe;
    logic        busy;

    int n_cmp;
    int n_bad;

    // model: phase 0 = no owner, 1 = owner driving, 2 = turnaround
    int          m_phase;
    int          m_own;
    int          m_ptr;
    int          m_beats;
    logic [3:0]  m_gnt;
    logic [31:0] m_out;
    logic        m_oe;

    bus_fill_arbiter #(
        .NREQ      (NREQ),
        .DW        (DW),
        .BW        (32),
        .MAX_BEATS (MAXB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .data_in  (data_in),
        .ext_mode (ext_mode),
        .gnt      (gnt),
        .bus_out  (bus_out),
        .bus_oe   (bus_oe),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] ref_ext(input logic [7:0] d, input logic [1:0] m);
        logic [31:0] w;
        w = {24'h000000, d};
        if (m == 2'd1 && d >= 8'h80) begin
            w = w + 32'hFFFF_FF00;
        end else if (m == 2'd2) begin
            w = w | 32'hFFFF_FF00;
        end else if (m == 2'd3) begin
`ifdef ARB_TRISTATE_EN
            w = {24'hzzzzzz, d};
`endif
        end
        return w;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_phase = 0; m_own = 0; m_ptr = 0; m_beats = 0;
            m_gnt = 4'b0000; m_out = IDLE_W; m_oe = 1'b0;
        end else if (m_phase == 0) begin
            if (req != 4'b0000) begin
                for (int k = NREQ - 1; k >= 0; k--) begin
                    if (req[(m_ptr + k) % NREQ]) m_own = (m_ptr + k) % NREQ;
                end
                m_phase = 1;
                m_beats = 0;
                m_gnt   = 4'(1 << m_own);
            end
        end else if (m_phase == 1) begin
            if (req[m_own]) begin
                m_out = ref_ext(data_in[m_own*8 +: 8], ext_mode[m_own*2 +: 2]);
                m_oe  = 1'b1;
                m_beats++;
                if (m_beats == MAXB) begin
                    m_gnt = 4'b0000;
                    m_phase = 2;
                end
            end else begin
                m_gnt = 4'b0000; m_oe = 1'b0; m_out = IDLE_W; m_phase = 2;
            end
        end else begin
            m_oe = 1'b0; m_out = IDLE_W; m_ptr = (m_own + 1) % NREQ; m_phase = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b1111;
        tick();
        tick();
        n_cmp += 4;
        if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt got %b want %b", gnt, 4'b0000); end
        if (bus_oe !== 1'b0) begin n_bad++; $display("FAIL reset_oe got %b want 0", bus_oe); end
        if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        if (bus_out !== IDLE_W) begin n_bad++; $display("FAIL reset_bus got %h want %h", bus_out, IDLE_W); end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (gnt !== 4'b0001) begin n_bad++; $display("FAIL reset_first_gnt got %b want 0001", gnt); end
    endtask

    task automatic test_single_fill();
        do_reset();
        req = 4'b0001; data_in = 32'h0000_0085; ext_mode = 8'b0000_0001;
        tick();
        n_cmp++;
        if (gnt !== 4'b0001) begin n_bad++; $display("FAIL single_gnt got %b want 0001", gnt); end
        for (int b = 0; b < MAXB; b++) begin
            tick();
            n_cmp += 2;
            if (bus_oe !== 1'b1) begin n_bad++; $display("FAIL single_oe beat %0d got %b want 1", b, bus_oe); end
            if (bus_out !== 32'hFFFF_FF85) begin n_bad++; $display("FAIL single_bus beat %0d got %h want ffffff85", b, bus_out); end
        end
        n_cmp++;
        if (gnt !== 4'b0000) begin n_bad++; $display("FAIL single_release got %b want 0000", gnt); end
        tick();
        n_cmp += 2;
        if (gnt !== 4'b0000) begin n_bad++; $display("FAIL single_gap_gnt got %b want 0000", gnt); end
        if (bus_oe !== 1'b0) begin n_bad++; $display("FAIL single_gap_oe got %b want 0", bus_oe); end
        tick();
        n_cmp += 2;
        if (gnt !== 4'b0001) begin n_bad++; $display("FAIL single_regrant got %b want 0001", gnt); end
        if (bus_oe !== 1'b0) begin n_bad++; $display("FAIL single_regrant_oe got %b want 0", bus_oe); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt;
        int o;
        do_reset();
        req = 4'b1111; data_in = 32'h4433_2211; ext_mode = 8'h00;
        tick();
        for (int k = 0; k < 5; k++) begin
            o = k % NREQ;
            exp_gnt = 4'(1 << o);
            if (k > 0) begin
                tick();
                n_cmp++;
                if (bus_oe !== 1'b0) begin n_bad++; $display("FAIL rr_gap2_oe owner %0d got %b want 0", o, bus_oe); end
            end
            n_cmp++;
            if (gnt !== exp_gnt) begin n_bad++; $display("FAIL rr_gnt step %0d got %b want %b", k, gnt, exp_gnt); end
            for (int b = 0; b < MAXB; b++) begin
                tick();
                n_cmp++;
                if (bus_oe !== 1'b1 || bus_out !== {24'h000000, data_in[o*8 +: 8]}) begin
                    n_bad++;
                    $display("FAIL rr_beat owner %0d beat %0d got oe=%b bus=%h want oe=1 bus=%h", o, b, bus_oe, bus_out, {24'h000000, data_in[o*8 +: 8]});
                end
            end
            tick();
            n_cmp++;
            if (bus_oe !== 1'b0) begin n_bad++; $display("FAIL rr_gap1_oe owner %0d got %b want 0", o, bus_oe); end
        end
    endtask

    task automatic test_modes();
        logic [7:0]  dv [2];
        logic [31:0] want;
        dv[0] = 8'hA5;
        dv[1] = 8'h0F;
        for (int d = 0; d < 2; d++) begin
            for (int m = 0; m < 4; m++) begin
                if (m == 0) want = {24'h000000, dv[d]};
                else if (m == 1) want = (d == 0) ? 32'hFFFF_FFA5 : 32'h0000_000F;
                else if (m == 2) want = {24'hFFFFFF, dv[d]};
`ifdef ARB_TRISTATE_EN
                else want = {24'hzzzzzz, dv[d]};
`else
                else want = {24'h000000, dv[d]};
`endif
                do_reset();
                req = 4'b0010;
                data_in = {16'h0000, dv[d], 8'h00};
                ext_mode = {4'b0000, 2'(m), 2'b00};
                tick();
                tick();
                n_cmp++;
                if (bus_out !== want || bus_oe !== 1'b1) begin
                    n_bad++;
                    $display("FAIL mode_%0d data %h got bus=%h oe=%b want bus=%h oe=1", m, dv[d], bus_out, bus_oe, want);
                end
            end
        end
    endtask

    task automatic test_early_release();
        do_reset();
        req = 4'b0100; data_in = 32'h0077_0000; ext_mode = 8'b0010_0000;
        tick();
        n_cmp++;
        if (gnt !== 4'b0100) begin n_bad++; $display("FAIL early_gnt got %b want 0100", gnt); end
        tick();
        tick();
        n_cmp++;
        if (bus_oe !== 1'b1 || bus_out !== 32'hFFFF_FF77) begin
            n_bad++; $display("FAIL early_beat got oe=%b bus=%h want oe=1 bus=ffffff77", bus_oe, bus_out);
        end
        req = 4'b0000;
        tick();
        n_cmp++;
        if (gnt !== 4'b0000 || bus_oe !== 1'b0 || bus_out !== IDLE_W) begin
            n_bad++; $display("FAIL early_drop got gnt=%b oe=%b bus=%h want 0000/0/%h", gnt, bus_oe, bus_out, IDLE_W);
        end
        req = 4'b1111;
        tick();
        n_cmp++;
        if (gnt !== 4'b0000) begin n_bad++; $display("FAIL early_turn_wait got %b want 0000", gnt); end
        tick();
        n_cmp++;
        if (gnt !== 4'b1000) begin n_bad++; $display("FAIL early_ptr3 got %b want 1000", gnt); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0010; data_in = 32'h0000_1200; ext_mode = 8'h00;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (gnt !== 4'b0000 || bus_oe !== 1'b0 || busy !== 1'b0 || bus_out !== IDLE_W) begin
            n_bad++; $display("FAIL midrst got gnt=%b oe=%b busy=%b bus=%h want 0000/0/0/%h", gnt, bus_oe, busy, bus_out, IDLE_W);
        end
        req = 4'b0011;
        tick();
        n_cmp++;
        if (gnt !== 4'b0001) begin n_bad++; $display("FAIL midrst_ptr0 got %b want 0001", gnt); end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 79) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
            end
            data_in  = $urandom;
            ext_mode = 8'($urandom);
            tick();
            n_cmp += 4;
            if (gnt !== m_gnt) begin n_bad++; $display("FAIL rand_gnt cyc %0d got %b want %b", c, gnt, m_gnt); end
            if (bus_oe !== m_oe) begin n_bad++; $display("FAIL rand_oe cyc %0d got %b want %b", c, bus_oe, m_oe); end
            if (bus_out !== m_out) begin n_bad++; $display("FAIL rand_bus cyc %0d got %h want %h", c, bus_out, m_out); end
            if (busy !== (m_phase != 0)) begin n_bad++; $display("FAIL rand_busy cyc %0d got %b want %b", c, busy, (m_phase != 0)); end
        end
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        req = 4'b0000;
        data_in = 32'h0000_0000;
        ext_mode = 8'h00;
        m_phase = 0; m_own = 0; m_ptr = 0; m_beats = 0;
        m_gnt = 4'b0000; m_out = IDLE_W; m_oe = 1'b0;
        test_reset();
        test_single_fill();
        test_round_robin();
        test_modes();
        test_early_release();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
